// File: rtl/switch_pkg.sv
// Shared definitions for the per-port egress reader (switch_port_tx).
// Contents:
//   tx_state_e   - egress FSM states (IDLE, PTR, LATCH, STREAM, DRAIN)
//   PTR_LEN_LSB/MSB - position of the frame-length field inside a descriptor
//   DEFAULT_IFG  - default inter-frame gap in clock cycles
package switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR,
    ST_LATCH,
    ST_STREAM,
    ST_DRAIN
  } tx_state_e;

  localparam int unsigned PTR_LEN_LSB = 0;
  localparam int unsigned PTR_LEN_MSB = 10;
  localparam int unsigned DEFAULT_IFG = 12;

endpackage

// File: rtl/switch_port_tx_if.sv
// Egress port bundle: pointer FIFO, data FIFO and MAC transmit signals.
//   ptr_fifo_empty / ptr_fifo_rd / ptr_fifo_dout[15:0]  descriptor FIFO
//   data_fifo_rd / data_fifo_dout[7:0]                  frame byte FIFO
//   tx_rdy / tx_sof / tx_dv / tx_dout[7:0]              MAC transmit side
// Modports: master = egress reader, slave = FIFOs + MAC.
interface switch_port_tx_if;

  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic        tx_rdy;
  logic        tx_sof;
  logic        tx_dv;
  logic [7:0]  tx_dout;

  modport master (
    input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_rdy,
    output ptr_fifo_rd, data_fifo_rd, tx_sof, tx_dv, tx_dout
  );

  modport slave (
    output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_rdy,
    input  ptr_fifo_rd, data_fifo_rd, tx_sof, tx_dv, tx_dout
  );

endinterface

// File: rtl/switch_port_tx_stats.sv
// Transmit statistics counters for one egress port (built only with TX_STATS_EN).
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   sof           first byte of a frame is on the MAC interface this cycle
//   frame_len     length of the frame currently being transmitted
//   drop          a zero-length descriptor is being discarded this cycle
//   frame_cnt     frames transmitted (wraps)
//   byte_cnt      bytes transmitted (wraps)
//   drop_cnt      zero-length descriptors discarded (wraps)
module switch_port_tx_stats #(
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sof,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             drop,
  output logic [31:0]      frame_cnt,
  output logic [31:0]      byte_cnt,
  output logic [15:0]      drop_cnt
);

  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] byte_cnt_q,  byte_cnt_d;
  logic [15:0] drop_cnt_q,  drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (sof) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
      byte_cnt_d  = byte_cnt_q + 32'(frame_len);
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign byte_cnt  = byte_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: rtl/switch_port_tx.sv
// Per-port egress reader: pops frame descriptors from the pointer FIFO and
// replays each frame from the data FIFO as a contiguous sof/dv/dout byte
// stream toward the MAC, enforcing an inter-frame gap and discarding
// zero-length descriptors.
// Ports:
//   clk, rstn       interface clock, asynchronous active-low reset
//   port_if         FIFO + MAC bundle (master side)
//   tx_busy         high while a frame is in flight or the gap is running
//   tx_frame_cnt    frames transmitted        (TX_STATS_EN, else 0)
//   tx_byte_cnt     bytes transmitted         (TX_STATS_EN, else 0)
//   tx_drop_cnt     zero-length drops         (TX_STATS_EN, else 0)
// Build option: define TX_STATS_EN to include the statistics counters.
module switch_port_tx
  import switch_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = DEFAULT_IFG,
  parameter int unsigned LEN_W      = PTR_LEN_MSB - PTR_LEN_LSB + 1
) (
  input  logic             clk,
  input  logic             rstn,
  switch_port_tx_if.master port_if,
  output logic             tx_busy,
  output logic [31:0]      tx_frame_cnt,
  output logic [31:0]      tx_byte_cnt,
  output logic [15:0]      tx_drop_cnt
);

  localparam int unsigned GAP_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES + 1);

  tx_state_e        state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ptr_rd_q, ptr_rd_d;
  logic             data_rd_q, data_rd_d;
  logic             rd_pipe_q, rd_pipe_d;
  logic             first_rd_q, first_rd_d;
  logic             first_pipe_q, first_pipe_d;
  logic             tx_sof_q, tx_sof_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_dout_q, tx_dout_d;
  logic [LEN_W-1:0] ptr_len;
  logic             drop_pulse;

  assign ptr_len = port_if.ptr_fifo_dout[PTR_LEN_LSB +: LEN_W];

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    len_d      = len_q;
    gap_d      = gap_q;
    ptr_rd_d   = 1'b0;
    data_rd_d  = data_rd_q;
    first_rd_d = 1'b0;
    drop_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (!port_if.ptr_fifo_empty && port_if.tx_rdy) begin
          ptr_rd_d = 1'b1;
          state_d  = ST_PTR;
        end
      end
      ST_PTR: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        len_d = ptr_len;
        if (ptr_len == '0) begin
          drop_pulse = 1'b1;
          gap_d      = GAP_W'(IFG_CYCLES);
          state_d    = ST_IDLE;
        end else begin
          rem_d      = ptr_len;
          data_rd_d  = 1'b1;
          first_rd_d = 1'b1;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rem_q == LEN_W'(1)) begin
          data_rd_d = 1'b0;
          state_d   = ST_DRAIN;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        // The last byte sits in the output stage next cycle; loading the gap
        // here lets it count down starting on that last tx_dv cycle, so the
        // next pop lands exactly IFG_CYCLES+1 cycles after it.
        gap_d   = GAP_W'(IFG_CYCLES);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Two-stage output pipeline: pop -> FIFO data valid -> registered tx.
    rd_pipe_d    = data_rd_q;
    first_pipe_d = first_rd_q;
    tx_dv_d      = rd_pipe_q;
    tx_sof_d     = first_pipe_q;
    tx_dout_d    = rd_pipe_q ? port_if.data_fifo_dout : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      ptr_rd_q     <= 1'b0;
      data_rd_q    <= 1'b0;
      rd_pipe_q    <= 1'b0;
      first_rd_q   <= 1'b0;
      first_pipe_q <= 1'b0;
      tx_sof_q     <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_dout_q    <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      ptr_rd_q     <= ptr_rd_d;
      data_rd_q    <= data_rd_d;
      rd_pipe_q    <= rd_pipe_d;
      first_rd_q   <= first_rd_d;
      first_pipe_q <= first_pipe_d;
      tx_sof_q     <= tx_sof_d;
      tx_dv_q      <= tx_dv_d;
      tx_dout_q    <= tx_dout_d;
    end
  end

  assign port_if.ptr_fifo_rd  = ptr_rd_q;
  assign port_if.data_fifo_rd = data_rd_q;
  assign port_if.tx_sof       = tx_sof_q;
  assign port_if.tx_dv        = tx_dv_q;
  assign port_if.tx_dout      = tx_dout_q;
  assign tx_busy              = (state_q != ST_IDLE) || (gap_q != '0);

  // Reserved descriptor bits are deliberately ignored.
  logic rsvd_unused;

`ifdef TX_STATS_EN
  switch_port_tx_stats #(
    .LEN_W (LEN_W)
  ) u_stats (
    .clk       (clk),
    .rstn      (rstn),
    .sof       (tx_sof_q),
    .frame_len (len_q),
    .drop      (drop_pulse),
    .frame_cnt (tx_frame_cnt),
    .byte_cnt  (tx_byte_cnt),
    .drop_cnt  (tx_drop_cnt)
  );
  assign rsvd_unused = ^port_if.ptr_fifo_dout[15:LEN_W];
`else
  assign tx_frame_cnt = '0;
  assign tx_byte_cnt  = '0;
  assign tx_drop_cnt  = '0;
  assign rsvd_unused  = ^{port_if.ptr_fifo_dout[15:LEN_W], drop_pulse, len_q};
`endif

endmodule
